// File: rtl/cam_cfg_pkg.sv
// Shared definitions for the camera configuration sequencer: ROM markers,
// FSM state encoding and the delay-length helper.
package cam_cfg_pkg;

  localparam logic [15:0] CFG_MARK_DELAY = 16'hFFF0;
  localparam logic [15:0] CFG_MARK_END   = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    SEND   = 3'd3,
    DELAY  = 3'd4,
    DONE   = 3'd5
  } cfg_state_e;

  // Number of clock cycles spent waiting for one delay marker.
  function automatic int cfg_delay_cycles(input int clk_hz, input int delay_ms);
    return clk_hz / 1000 * delay_ms;
  endfunction

endpackage

// File: rtl/cfg_delay_timer.sv
// Down-counter for the in-band delay marker; o_expired is high while the
// count sits at zero.
module cfg_delay_timer #(
  parameter int DELAY_CYCLES = 5
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_load,
  input  logic i_dec,
  output logic o_expired
);

  localparam int CW = $clog2(DELAY_CYCLES + 1);

  logic [CW-1:0] r_count;

  // Loading DELAY_CYCLES-1 makes the zero cycle the last one of the dwell.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CW'(DELAY_CYCLES - 1);
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/cam_cfg_seq.sv
// Camera configuration sequencer: walks the config ROM and issues one SCCB
// register write per word, honouring delay and end-of-table markers.
module cam_cfg_seq
  import cam_cfg_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int DELAY_MS    = 10
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_start,
  output logic [7:0]  o_rom_addr,
  input  logic [15:0] i_rom_data,
  output logic        o_sccb_valid,
  input  logic        i_sccb_ready,
  output logic [7:0]  o_sccb_reg,
  output logic [7:0]  o_sccb_data,
  output logic        o_busy,
  output logic        o_done
);

  localparam int DELAY_CYCLES = cfg_delay_cycles(CLK_FREQ_HZ, DELAY_MS);

  cfg_state_e r_state;
  logic [7:0] r_rom_addr;
  logic       r_sccb_valid;
  logic [7:0] r_sccb_reg;
  logic [7:0] r_sccb_data;
  logic       r_busy;
  logic       r_done;

  logic w_load_delay;
  logic w_dec_delay;
  logic w_expired;
  logic w_advance;
  logic w_last_addr;

  assign w_load_delay = (r_state == DECODE) && (i_rom_data == CFG_MARK_DELAY);
  assign w_dec_delay  = (r_state == DELAY);
  assign w_last_addr  = (r_rom_addr == 8'hFF);
  assign w_advance    = ((r_state == SEND) && r_sccb_valid && i_sccb_ready) ||
                        ((r_state == DELAY) && w_expired);

  cfg_delay_timer #(
    .DELAY_CYCLES(DELAY_CYCLES)
  ) u_delay_timer (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_load    (w_load_delay),
    .i_dec     (w_dec_delay),
    .o_expired (w_expired)
  );

  // Main sequencer. Moving to the next ROM entry is shared by SEND and DELAY
  // and is handled after the state case; the table never wraps past 255.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state      <= IDLE;
      r_rom_addr   <= 8'd0;
      r_sccb_valid <= 1'b0;
      r_sccb_reg   <= 8'd0;
      r_sccb_data  <= 8'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_rom_addr <= 8'd0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_state    <= FETCH;
          end
        end
        FETCH: begin
          r_state <= DECODE;
        end
        DECODE: begin
          if (i_rom_data == CFG_MARK_END) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (i_rom_data == CFG_MARK_DELAY) begin
            r_state <= DELAY;
          end else begin
            r_sccb_reg   <= i_rom_data[15:8];
            r_sccb_data  <= i_rom_data[7:0];
            r_sccb_valid <= 1'b1;
            r_state      <= SEND;
          end
        end
        SEND: begin
          if (i_sccb_ready) begin
            r_sccb_valid <= 1'b0;
          end
        end
        DELAY: begin
          r_state <= DELAY;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase

      if (w_advance) begin
        if (w_last_addr) begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= DONE;
        end else begin
          r_rom_addr <= r_rom_addr + 8'd1;
          r_state    <= FETCH;
        end
      end
    end
  end

  assign o_rom_addr   = r_rom_addr;
  assign o_sccb_valid = r_sccb_valid;
  assign o_sccb_reg   = r_sccb_reg;
  assign o_sccb_data  = r_sccb_data;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_cam_cfg_seq.sv
// Self-checking bench for cam_cfg_seq: transaction-level model of the ROM
// walk, randomized ready/start noise, and directed corner cases.
module tb_cam_cfg_seq;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  o_rom_addr;
  logic [15:0] i_rom_data;
  logic        o_sccb_valid;
  logic        i_sccb_ready = 1'b0;
  logic [7:0]  o_sccb_reg;
  logic [7:0]  o_sccb_data;
  logic        o_busy;
  logic        o_done;

  cam_cfg_seq #(
    .CLK_FREQ_HZ(1000),
    .DELAY_MS   (5)
  ) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_start     (i_start),
    .o_rom_addr  (o_rom_addr),
    .i_rom_data  (i_rom_data),
    .o_sccb_valid(o_sccb_valid),
    .i_sccb_ready(i_sccb_ready),
    .o_sccb_reg  (o_sccb_reg),
    .o_sccb_data (o_sccb_data),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 i_clk = ~i_clk;

  logic [15:0] romMem [256];

  always @(posedge i_clk) i_rom_data <= romMem[o_rom_addr];

  typedef struct {
    logic [7:0] regA;
    logic [7:0] dataV;
    logic [7:0] addr;
    int         gap;
  } expWr_t;

  expWr_t expQ[$];
  int endGap;

  int assertCnt = 0;
  int failCnt = 0;
  bit armed = 0;
  bit doneSeen = 0;
  bit prevStall = 0;
  int gapCnt = 0;
  int stallRun = 0;
  int xfers = 0;
  int firstStall = -1;
  logic [7:0] firstReg = 8'h00;
  logic [7:0] firstData = 8'h00;

  int readyMode = 0;
  bit noiseEn = 0;
  int startReqCnt = 0;
  int startAckCnt = 0;
  int stallCnt = 0;

  // Drives start (requested pulses plus optional noise while busy) and ready.
  always @(posedge i_clk) begin
    #1;
    if (startReqCnt != startAckCnt) begin
      i_start = 1'b1;
      startAckCnt = startReqCnt;
    end else begin
      i_start = noiseEn && o_busy && ($urandom_range(0, 1) == 1);
    end
    case (readyMode)
      0: i_sccb_ready = 1'b1;
      1: i_sccb_ready = ($urandom_range(0, 2) != 0);
      2: begin
        if (stallCnt >= 10) begin
          i_sccb_ready = 1'b1;
        end else begin
          i_sccb_ready = 1'b0;
          if (o_sccb_valid) stallCnt++;
        end
      end
      default: i_sccb_ready = 1'b0;
    endcase
    if (readyMode != 2) stallCnt = 0;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCnt++;
    if (act !== exp) begin
      failCnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Walks the ROM as the sequencer should: each write costs 3 cycles, each
  // delay marker adds FETCH+DECODE+5 DELAY cycles, the end marker costs 2.
  task automatic buildModel();
    int d;
    logic [15:0] w;
    expQ.delete();
    d = 0;
    endGap = 0;
    for (int a = 0; a < 256; a++) begin
      w = romMem[a];
      if (w == 16'hFFFF) begin
        endGap = 2 + 7 * d;
        break;
      end else if (w == 16'hFFF0) begin
        d++;
      end else begin
        expQ.push_back('{regA: w[15:8], dataV: w[7:0], addr: 8'(a), gap: 3 + 7 * d});
        d = 0;
      end
      if (a == 255) endGap = 7 * d;
    end
  endtask

  task automatic compareLoop();
    forever begin
      @(negedge i_clk);
      if (armed) begin
        if (prevStall) checkOutput("validHold", 32'(o_sccb_valid), 1);
        if (o_done) begin
          if (!doneSeen) begin
            checkOutput("endGap", gapCnt, endGap);
            checkOutput("allWritesSeen", expQ.size(), 0);
            doneSeen = 1;
          end
          checkOutput("doneBusy", 32'(o_busy), 0);
          checkOutput("doneValid", 32'(o_sccb_valid), 0);
        end else begin
          checkOutput("busy", 32'(o_busy), 1);
          if (o_sccb_valid) begin
            if (expQ.size() == 0) begin
              checkOutput("extraWrite", 0, 1);
            end else begin
              checkOutput("sccbReg", 32'(o_sccb_reg), 32'(expQ[0].regA));
              checkOutput("sccbData", 32'(o_sccb_data), 32'(expQ[0].dataV));
              checkOutput("romAddr", 32'(o_rom_addr), 32'(expQ[0].addr));
              if (i_sccb_ready) begin
                gapCnt++;
                checkOutput("writeGap", gapCnt, expQ[0].gap);
                if (xfers == 0) begin
                  firstStall = stallRun;
                  firstReg = o_sccb_reg;
                  firstData = o_sccb_data;
                end
                xfers++;
                void'(expQ.pop_front());
                gapCnt = 0;
                stallRun = 0;
              end else begin
                stallRun++;
              end
            end
          end else begin
            gapCnt++;
          end
        end
        prevStall = o_sccb_valid && !i_sccb_ready && !o_done;
      end
    end
  endtask

  task automatic applyStimulus();
    @(posedge i_clk);
    #2;
    armed = 0;
    buildModel();
    startReqCnt++;
    @(posedge i_clk);
    @(posedge i_clk);
    #2;
    checkOutput("startBusy", 32'(o_busy), 1);
    checkOutput("startDone", 32'(o_done), 0);
    checkOutput("startAddr", 32'(o_rom_addr), 0);
    gapCnt = 0;
    stallRun = 0;
    doneSeen = 0;
    prevStall = 0;
    xfers = 0;
    firstStall = -1;
    armed = 1;
  endtask

  task automatic waitDone(input int budget);
    for (int c = 0; c < budget && !doneSeen; c++) @(negedge i_clk);
    checkOutput("doneWithinBudget", 32'(doneSeen), 1);
    repeat (3) @(negedge i_clk);
  endtask

  task automatic loadSmallRom();
    for (int a = 0; a < 256; a++) romMem[a] = 16'hFFFF;
    romMem[0] = 16'h1280;
    romMem[1] = 16'hFFF0;
    romMem[2] = 16'h1204;
    romMem[3] = 16'hFFFF;
  endtask

  task automatic mainSequence();
    int len;
    int r;
    logic [15:0] w;

    loadSmallRom();
    i_rstn = 1'b0;
    repeat (3) @(negedge i_clk);
    checkOutput("rstAddr", 32'(o_rom_addr), 0);
    checkOutput("rstValid", 32'(o_sccb_valid), 0);
    checkOutput("rstReg", 32'(o_sccb_reg), 0);
    checkOutput("rstData", 32'(o_sccb_data), 0);
    checkOutput("rstBusy", 32'(o_busy), 0);
    checkOutput("rstDone", 32'(o_done), 0);
    i_rstn = 1'b1;

    // Two writes separated by one delay; the model itself is pinned first.
    buildModel();
    checkOutput("modelSize1", expQ.size(), 2);
    checkOutput("modelGap0", expQ[0].gap, 3);
    checkOutput("modelGap1", expQ[1].gap, 10);
    checkOutput("modelEnd1", endGap, 2);
    readyMode = 0;
    applyStimulus();
    waitDone(200);
    repeat (5) @(negedge i_clk);
    checkOutput("t1Xfers", xfers, 2);
    checkOutput("t1Done", 32'(o_done), 1);
    checkOutput("t1First", 32'({firstReg, firstData}), 32'h1280);

    noiseEn = 1;
    applyStimulus();
    waitDone(200);
    noiseEn = 0;
    checkOutput("t5Xfers", xfers, 2);

    readyMode = 2;
    applyStimulus();
    waitDone(200);
    checkOutput("t2Stall", firstStall, 10);
    checkOutput("t2Xfers", xfers, 2);

    readyMode = 3;
    applyStimulus();
    for (int c = 0; c < 20 && !o_sccb_valid; c++) @(negedge i_clk);
    checkOutput("t4InSend", 32'(o_sccb_valid), 1);
    armed = 0;
    i_rstn = 1'b0;
    @(negedge i_clk);
    checkOutput("t4Valid", 32'(o_sccb_valid), 0);
    checkOutput("t4Busy", 32'(o_busy), 0);
    checkOutput("t4Addr", 32'(o_rom_addr), 0);
    i_rstn = 1'b1;
    readyMode = 0;
    applyStimulus();
    waitDone(200);
    checkOutput("t4Replay", 32'({firstReg, firstData}), 32'h1280);
    checkOutput("t4Xfers", xfers, 2);

    // Production-sized table: 77 entries with an end marker at 77.
    for (int a = 0; a < 256; a++) romMem[a] = 16'hFFFF;
    romMem[0] = 16'h1280;
    romMem[1] = 16'hFFF0;
    for (int a = 2; a < 75; a++) romMem[a] = {8'(a), 8'(255 - a)};
    romMem[75] = 16'h4110;
    romMem[76] = 16'h13A7;
    buildModel();
    checkOutput("modelSize3", expQ.size(), 76);
    checkOutput("modelPenult", 32'({expQ[74].regA, expQ[74].dataV}), 32'h4110);
    checkOutput("modelLast", 32'({expQ[75].regA, expQ[75].dataV}), 32'h13A7);
    checkOutput("modelDelayGap", expQ[1].gap, 10);
    readyMode = 1;
    applyStimulus();
    waitDone(2000);
    checkOutput("t3Xfers", xfers, 76);
    checkOutput("t3DoneAddr", 32'(o_rom_addr), 77);

    for (int iter = 0; iter < 3; iter++) begin
      len = $urandom_range(20, 60);
      for (int a = 0; a < 256; a++) begin
        r = $urandom_range(0, 15);
        w = 16'($urandom);
        if (w[15:8] == 8'hFF) w[15:8] = 8'h7F;
        if (r == 0) w = 16'hFFF0;
        else if (r == 1) w = {8'hFF, 8'($urandom_range(0, 239))};
        romMem[a] = w;
      end
      romMem[len] = 16'hFFFF;
      readyMode = 1;
      noiseEn = 1;
      applyStimulus();
      waitDone(3000);
      noiseEn = 0;
    end

    for (int a = 0; a < 256; a++) romMem[a] = 16'h1111;
    buildModel();
    checkOutput("modelEnd6", endGap, 0);
    readyMode = 0;
    applyStimulus();
    waitDone(2000);
    checkOutput("t6Xfers", xfers, 256);
    checkOutput("t6Addr", 32'(o_rom_addr), 255);
    checkOutput("t6Done", 32'(o_done), 1);
    armed = 0;
  endtask

  initial begin
    fork
      compareLoop();
      mainSequence();
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
